// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter: memory command
// encodings, transaction owner, arbiter state and the arbitration rule.
package mem_arbiter_pkg;

  // Memory command: read or write.
  typedef enum logic {
    M_XRD = 1'b0,
    M_XWR = 1'b1
  } MemoryWriteSignal;

  // Memory access size / sign-extension type.
  typedef enum logic [2:0] {
    MT_X  = 3'd0,
    MT_B  = 3'd1,
    MT_H  = 3'd2,
    MT_W  = 3'd3,
    MT_D  = 3'd4,
    MT_BU = 3'd5,
    MT_HU = 3'd6,
    MT_WU = 3'd7
  } MemoryMaskType;

  // Which requester owns the transaction currently in flight.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } MemArbOwner;

  // Arbiter phase: free, request presented but not yet taken, waiting on response.
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } MemArbState;

  // Data normally wins; fetch wins when it is alone or has been starved too long.
  function automatic MemArbOwner pick_winner(input logic i_valid,
                                             input logic d_valid,
                                             input logic fetch_first);
    if (i_valid && (!d_valid || fetch_first)) return OWN_I;
    if (d_valid) return OWN_D;
    return OWN_NONE;
  endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating fetch-starvation counter for the memory arbiter fairness build
// (MEM_ARB_FAIRNESS_EN). Counts cycles a fetch waits without acceptance.
`ifdef MEM_ARB_FAIRNESS_EN
module mem_arb_starve_ctr #(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] MAX_C = CW'(STARVE_MAX);

  logic [CW-1:0] cnt_q, cnt_d;

  // Clear wins over increment; increment stops at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX_C)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max_o = (cnt_q == MAX_C);

endmodule
`endif

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported backing memory between the fetch port and
// the data port. One transaction in flight at a time; the response is routed
// back to the requester that issued it. Define MEM_ARB_FAIRNESS_EN to let a
// starved fetch overtake data after STARVE_MAX denied cycles.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  // instruction fetch port
  input  logic              i_req_valid,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_req_ready,
  output logic              i_resp_valid,
  output logic [DATA_W-1:0] i_resp_data,
  // data port
  input  logic              d_req_valid,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_req_data,
  input  logic              d_req_fcn,
  input  logic [2:0]        d_req_typ,
  output logic              d_req_ready,
  output logic              d_resp_valid,
  output logic [DATA_W-1:0] d_resp_data,
  // backing memory
  output logic              m_req_valid,
  input  logic              m_req_ready,
  output logic [ADDR_W-1:0] m_req_addr,
  output logic [DATA_W-1:0] m_req_data,
  output logic              m_req_fcn,
  output logic [2:0]        m_req_typ,
  input  logic              m_resp_valid,
  input  logic [DATA_W-1:0] m_resp_data,
  output logic              busy
);

  MemArbState state_q, state_d;
  MemArbOwner owner_q, owner_d;
  MemArbOwner winner;
  MemArbOwner sel;
  logic       fetch_first;

`ifdef MEM_ARB_FAIRNESS_EN
  logic starve_at_max;

  mem_arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve_ctr (
    .clk_i    (clk),
    .rst_i    (rst),
    .inc_i    (i_req_valid & ~i_req_ready),
    .clr_i    (i_req_valid & i_req_ready),
    .at_max_o (starve_at_max)
  );

  assign fetch_first = starve_at_max;
`else
  assign fetch_first = 1'b0;
`endif

  assign winner = pick_winner(i_req_valid, d_req_valid, fetch_first);

  // Next-state logic, request mux and handshake routing. The handshakes are
  // combinational so that accept and response land in the same cycle as the
  // memory's ready/valid; only state and owner are registered.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    sel          = OWN_NONE;
    i_req_ready  = 1'b0;
    d_req_ready  = 1'b0;
    i_resp_valid = 1'b0;
    i_resp_data  = '0;
    d_resp_valid = 1'b0;
    d_resp_data  = '0;
    m_req_valid  = 1'b0;
    m_req_addr   = '0;
    m_req_data   = '0;
    m_req_fcn    = M_XRD;
    m_req_typ    = MT_X;

    unique case (state_q)
      ARB_IDLE: begin
        sel = winner;
        if (winner != OWN_NONE) begin
          owner_d = winner;
          state_d = m_req_ready ? ARB_WAIT : ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        // grant stays with the owner until the memory takes the request
        sel = owner_q;
        if (m_req_ready) begin
          state_d = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (m_resp_valid) begin
          if (owner_q == OWN_I) begin
            i_resp_valid = 1'b1;
            i_resp_data  = m_resp_data;
          end else if (owner_q == OWN_D) begin
            d_resp_valid = 1'b1;
            d_resp_data  = m_resp_data;
          end
          owner_d = OWN_NONE;
          state_d = ARB_IDLE;
        end
      end
      default: begin
        owner_d = OWN_NONE;
        state_d = ARB_IDLE;
      end
    endcase

    if (sel == OWN_I) begin
      m_req_valid = 1'b1;
      m_req_addr  = i_req_addr;
      m_req_fcn   = M_XRD;
      m_req_typ   = MT_W;
      i_req_ready = m_req_ready;
    end else if (sel == OWN_D) begin
      m_req_valid = 1'b1;
      m_req_addr  = d_req_addr;
      m_req_data  = d_req_data;
      m_req_fcn   = d_req_fcn;
      m_req_typ   = d_req_typ;
      d_req_ready = m_req_ready;
    end

    // every handshake output is held low while reset is asserted
    if (rst) begin
      i_req_ready  = 1'b0;
      d_req_ready  = 1'b0;
      i_resp_valid = 1'b0;
      i_resp_data  = '0;
      d_resp_valid = 1'b0;
      d_resp_data  = '0;
      m_req_valid  = 1'b0;
      m_req_addr   = '0;
      m_req_data   = '0;
      m_req_fcn    = M_XRD;
      m_req_typ    = MT_X;
    end
  end

  // State and owner registers; reset abandons any outstanding transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_NONE;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  assign busy = ~rst & ((state_q != ARB_IDLE) | i_req_valid | d_req_valid);

`ifndef SYNTHESIS
  // A requester must hold valid until its request is accepted.
  a_fetch_hold: assert property (@(posedge clk) disable iff (rst)
    (i_req_valid && !i_req_ready) |=> i_req_valid);
  a_data_hold: assert property (@(posedge clk) disable iff (rst)
    (d_req_valid && !d_req_ready) |=> d_req_valid);
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned SMAX = 8;

`ifdef MEM_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req_valid;
  logic [AW-1:0] i_req_addr;
  logic          i_req_ready;
  logic          i_resp_valid;
  logic [DW-1:0] i_resp_data;
  logic          d_req_valid;
  logic [AW-1:0] d_req_addr;
  logic [DW-1:0] d_req_data;
  logic          d_req_fcn;
  logic [2:0]    d_req_typ;
  logic          d_req_ready;
  logic          d_resp_valid;
  logic [DW-1:0] d_resp_data;
  logic          m_req_valid;
  logic          m_req_ready;
  logic [AW-1:0] m_req_addr;
  logic [DW-1:0] m_req_data;
  logic          m_req_fcn;
  logic [2:0]    m_req_typ;
  logic          m_resp_valid;
  logic [DW-1:0] m_resp_data;
  logic          busy;

  mem_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_data(d_req_data),
    .d_req_fcn(d_req_fcn), .d_req_typ(d_req_typ), .d_req_ready(d_req_ready),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
    .m_req_data(m_req_data), .m_req_fcn(m_req_fcn), .m_req_typ(m_req_typ),
    .m_resp_valid(m_resp_valid), .m_resp_data(m_resp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_err    = 0;
  int n_checks = 0;

  // Reference model: who holds the memory (0 nobody, 1 fetch, 2 data),
  // whether the memory has taken that request, and fetch wait time.
  int who      = 0;
  bit accepted = 1'b0;
  int starve   = 0;
  int drv      = 0;
  logic          e_irdy, e_drdy, e_ivld, e_dvld, e_mv, e_busy, e_fcn;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_idata, e_ddata;
  logic [2:0]    e_typ;
  logic          obs_irdy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] flags();
    return {i_req_ready, d_req_ready, i_resp_valid, d_resp_valid, m_req_valid, busy};
  endfunction

  function automatic int choose();
    if (i_req_valid && d_req_valid) return (FAIR && starve >= int'(SMAX)) ? 1 : 2;
    if (d_req_valid) return 2;
    if (i_req_valid) return 1;
    return 0;
  endfunction

  task automatic model_outputs();
    {e_irdy, e_drdy, e_ivld, e_dvld, e_mv, e_busy} = '0;
    e_addr = '0; e_wdata = '0; e_fcn = 1'b0; e_typ = '0; e_idata = '0; e_ddata = '0;
    drv = 0;
    if (rst) return;
    e_busy = (who != 0) || i_req_valid || d_req_valid;
    if (who == 0) drv = choose();
    else if (!accepted) drv = who;
    if (drv == 1) begin
      e_mv = 1'b1; e_addr = i_req_addr; e_fcn = M_XRD; e_typ = MT_W; e_irdy = m_req_ready;
    end else if (drv == 2) begin
      e_mv = 1'b1; e_addr = d_req_addr; e_wdata = d_req_data; e_fcn = d_req_fcn;
      e_typ = d_req_typ; e_drdy = m_req_ready;
    end
    if (accepted && m_resp_valid) begin
      if (who == 1) begin e_ivld = 1'b1; e_idata = m_resp_data; end
      else begin e_dvld = 1'b1; e_ddata = m_resp_data; end
    end
  endtask

  task automatic model_update();
    if (rst) begin who = 0; accepted = 1'b0; starve = 0; return; end
    if (e_irdy) starve = 0;
    else if (i_req_valid && starve < int'(SMAX)) starve++;
    if (accepted) begin
      if (m_resp_valid) begin who = 0; accepted = 1'b0; end
    end else if (drv != 0) begin
      who = drv; accepted = m_req_ready;
    end
  endtask

  // Compare all outputs against the model, away from the clock edge.
  task automatic settle(input string tag);
    #1;
    model_outputs();
    obs_irdy = i_req_ready;
    chk({tag, ":flags"}, 64'(flags()), 64'({e_irdy, e_drdy, e_ivld, e_dvld, e_mv, e_busy}));
    if (e_mv) begin
      chk({tag, ":m_addr"}, 64'(m_req_addr), 64'(e_addr));
      chk({tag, ":m_cmd"}, 64'({m_req_fcn, m_req_typ}), 64'({e_fcn, e_typ}));
      if (drv == 2) chk({tag, ":m_wdata"}, 64'(m_req_data), 64'(e_wdata));
    end
    if (e_ivld) chk({tag, ":i_rdata"}, 64'(i_resp_data), 64'(e_idata));
    if (e_dvld) chk({tag, ":d_rdata"}, 64'(d_resp_data), 64'(e_ddata));
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    i_req_valid = 1'b0; i_req_addr = '0;
    d_req_valid = 1'b0; d_req_addr = '0; d_req_data = '0; d_req_fcn = 1'b0; d_req_typ = '0;
    m_req_ready = 1'b0; m_resp_valid = 1'b0; m_resp_data = '0;
  endtask

  initial begin
    int  first_grant;
    bit  i_free, d_free;

    rst = 1'b1;
    clear_inputs();
    @(negedge clk);

    // reset state
    settle("rst0"); chk("reset_flags", 64'(flags()), 64'(0)); tick();
    settle("rst1"); tick();
    rst = 1'b0;

    // fetch alone, response three cycles after accept
    i_req_valid = 1'b1; i_req_addr = 32'h100; m_req_ready = 1'b1;
    settle("t1c0"); chk("t1_accept", 64'({i_req_ready, m_req_addr}), 64'({1'b1, 32'h100})); tick();
    i_req_valid = 1'b0; i_req_addr = '0; m_req_ready = 1'b0;
    settle("t1c1"); tick();
    settle("t1c2"); tick();
    m_resp_valid = 1'b1; m_resp_data = 32'hDEADBEEF;
    settle("t1c3");
    chk("t1_resp", 64'({i_resp_valid, d_resp_valid, i_resp_data}), 64'({1'b1, 1'b0, 32'hDEADBEEF}));
    tick();
    m_resp_valid = 1'b0; m_resp_data = '0;

    // simultaneous fetch and store: store first, fetch after the store response
    i_req_valid = 1'b1; i_req_addr = 32'h200;
    d_req_valid = 1'b1; d_req_addr = 32'h400; d_req_data = 32'h55; d_req_fcn = M_XWR; d_req_typ = MT_W;
    m_req_ready = 1'b1;
    settle("t2c0");
    chk("t2_data_first", 64'({d_req_ready, i_req_ready, m_req_fcn, m_req_addr}),
        64'({1'b1, 1'b0, 1'b1, 32'h400}));
    tick();
    d_req_valid = 1'b0; m_resp_valid = 1'b1; m_resp_data = 32'h0;
    settle("t2c1"); chk("t2_no_issue_in_resp", 64'({d_resp_valid, m_req_valid, i_req_ready}), 64'(3'b100)); tick();
    m_resp_valid = 1'b0;
    settle("t2c2"); chk("t2_fetch_next", 64'({i_req_ready, m_req_fcn, m_req_addr}), 64'({1'b1, 1'b0, 32'h200})); tick();
    i_req_valid = 1'b0; m_req_ready = 1'b0; m_resp_valid = 1'b1; m_resp_data = 32'h1234;
    settle("t2c3"); tick();
    m_resp_valid = 1'b0;

    // fetch stalled by memory, data arrives mid-stall: grant must not move
    i_req_valid = 1'b1; i_req_addr = 32'h200; m_req_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) begin
        d_req_valid = 1'b1; d_req_addr = 32'h400; d_req_data = 32'h77; d_req_fcn = M_XWR;
      end
      settle("t3hold");
      chk("t3_locked", 64'({m_req_valid, m_req_addr, i_req_ready, d_req_ready}), 64'({1'b1, 32'h200, 2'b00}));
      tick();
    end
    m_req_ready = 1'b1;
    settle("t3c4"); chk("t3_accept", 64'({i_req_ready, d_req_ready, m_req_addr}), 64'({2'b10, 32'h200})); tick();
    i_req_valid = 1'b0; m_resp_valid = 1'b1; m_resp_data = 32'hA5A5;
    settle("t3c5"); chk("t3_resp_owner", 64'({i_resp_valid, d_resp_valid}), 64'(2'b10)); tick();
    m_resp_valid = 1'b0;
    settle("t3c6"); tick();
    d_req_valid = 1'b0; m_resp_valid = 1'b1; m_resp_data = 32'h5A5A;
    settle("t3c7"); tick();
    m_resp_valid = 1'b0; m_req_ready = 1'b0;

    // reset while waiting on a response; the late response must be dropped
    i_req_valid = 1'b1; i_req_addr = 32'h300; m_req_ready = 1'b1;
    settle("t4c0"); tick();
    i_req_valid = 1'b0; m_req_ready = 1'b0; rst = 1'b1;
    settle("t4c1"); tick();
    rst = 1'b0;
    settle("t4c2"); tick();
    m_resp_valid = 1'b1; m_resp_data = 32'hBAD;
    settle("t4c3"); chk("t4_late_resp_dropped", 64'(flags()), 64'(0)); tick();

    // stray response while idle, then while a request is still unaccepted
    settle("t5c0"); chk("t5_stray_idle", 64'(flags()), 64'(0)); tick();
    m_resp_valid = 1'b0;
    d_req_valid = 1'b1; d_req_addr = 32'h80; d_req_data = 32'h99; d_req_fcn = M_XRD; d_req_typ = MT_BU;
    settle("t5c1"); tick();
    m_resp_valid = 1'b1; m_resp_data = 32'h66;
    settle("t5c2"); chk("t5_stray_issue", 64'({d_resp_valid, m_req_valid, m_req_typ}), 64'({2'b01, MT_BU})); tick();
    m_resp_valid = 1'b0; m_req_ready = 1'b1;
    settle("t5c3"); tick();
    d_req_valid = 1'b0; m_req_ready = 1'b0; m_resp_valid = 1'b1; m_resp_data = 32'h77;
    settle("t5c4"); chk("t5_real_resp", 64'({d_resp_valid, d_resp_data}), 64'({1'b1, 32'h77})); tick();
    m_resp_valid = 1'b0;

    // continuous data traffic with a waiting fetch
    rst = 1'b1; settle("t6rst"); tick(); rst = 1'b0;
    first_grant = -1;
    i_req_valid = 1'b1; i_req_addr = 32'h1000;
    d_req_valid = 1'b1; d_req_addr = 32'h2000; d_req_fcn = M_XRD; d_req_typ = MT_W;
    m_req_ready = 1'b1; m_resp_valid = 1'b1; m_resp_data = 32'hC0DE;
    for (int c = 0; c < 24; c++) begin
      settle("t6");
      if (obs_irdy && first_grant < 0) first_grant = c;
      if (e_drdy) d_req_addr = d_req_addr + 32'h4;
      tick();
    end
    chk("t6_first_fetch_grant", 64'(first_grant), FAIR ? 64'(8) : 64'(-1));

    // random traffic, including strays and occasional reset
    rst = 1'b1; clear_inputs(); settle("t7rst"); tick(); rst = 1'b0;
    i_free = 1'b1; d_free = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (i_free) begin
        i_req_valid = ($urandom_range(0, 2) != 0);
        i_req_addr  = $urandom;
      end
      if (d_free) begin
        d_req_valid = ($urandom_range(0, 2) != 0);
        d_req_addr  = $urandom;
        d_req_data  = $urandom;
        d_req_fcn   = 1'($urandom_range(0, 1));
        d_req_typ   = 3'($urandom_range(0, 7));
      end
      m_req_ready  = ($urandom_range(0, 2) != 0);
      m_resp_valid = 1'($urandom_range(0, 1));
      m_resp_data  = $urandom;
      rst          = ($urandom_range(0, 39) == 0);
      settle("t7");
      i_free = rst || !i_req_valid || e_irdy;
      d_free = rst || !d_req_valid || e_drdy;
      tick();
    end
    rst = 1'b1; clear_inputs();
    settle("t7end"); tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
